if_fetch_unit: RTL and testbench

Instruction-fetch stage of the riscv32i core. It owns the program counter, issues single-outstanding requests to instruction memory over a req/ready + rvalid handshake, and buffers one fetched instruction. It presents pc/instr to the IF/ID pipeline register. It honours stall from the hazard unit and redirects from branch/jump resolution, and discards any in-flight response made stale by a redirect.

---
 rtl/if_fetch_unit_if.sv | 10 +
 rtl/if_fetch_unit.sv | 61 ++++++
 tb/tb_if_fetch_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory request/response bus
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  modport master(output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner, single-outstanding imem fetch, one-entry IF/ID buffer
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  if_fetch_unit_if.master       imem,
  output logic                  if_valid,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_instr,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;
  state_t      state, state_n;
  logic [31:0] pc, instr_buf;
  logic        pend_after;
  // next state; a redirect that leaves a response in flight must drain it first
  always_comb begin
    pend_after = (state == WAIT && !imem.imem_rvalid) || (state == REQ && imem.imem_ready) ||
                 (state == DRAIN && !imem.imem_rvalid);
    state_n = redirect_valid ? (pend_after ? DRAIN : REQ) :
              state == IDLE  ? REQ :
              state == REQ   ? (imem.imem_ready ? WAIT : REQ) :
              state == WAIT  ? (imem.imem_rvalid ? HOLD : WAIT) :
              state == HOLD  ? (stall ? HOLD : REQ) :
              state == DRAIN ? (imem.imem_rvalid ? REQ : DRAIN) : IDLE;
  end
  // state, pc, buffer and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      if_valid      <= 1'b0;
      if_pc         <= '0;
      instr_buf     <= NOP_INSTR;
      imem.imem_req <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      imem.imem_req <= state_n == REQ;
      busy          <= state_n == WAIT || state_n == DRAIN;
      if (redirect_valid) begin
        pc       <= redirect_pc & ~32'd3;
        if_valid <= 1'b0;
      end else if (state == WAIT && imem.imem_rvalid) begin
        instr_buf <= imem.imem_rdata;
        if_pc     <= pc;
        if_valid  <= 1'b1;
      end else if (state == HOLD && !stall) begin
        pc       <= pc + 32'd4;
        if_valid <= 1'b0;
      end
    end
  end
  assign imem.imem_addr = {pc[31:2], 2'b00};
  assign if_instr       = if_valid ? instr_buf : NOP_INSTR;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed plus random checks against a transaction-level fetch model
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 0, reset = 1, stall = 0, redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic        if_valid, busy;
  logic [31:0] if_pc, if_instr;
  int          n_chk = 0, n_fail = 0;
  logic        m_req, m_out, m_stale, m_valid, m_started;
  logic [31:0] m_pc, m_ipc, m_instr;
  bit          pend, acc;
  int          cnt;
  if_fetch_unit_if bus();
  if_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem(bus), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset;
    m_pc = 32'h0; m_req = 0; m_out = 0; m_stale = 0; m_valid = 0;
    m_ipc = 32'h0; m_instr = NOP; m_started = 0;
  endtask
  task automatic model_step;
    bit a, nout;
    a = m_req && bus.imem_ready;
    nout = (m_out && !bus.imem_rvalid) || a;
    if (redirect_valid) begin
      m_pc = redirect_pc & ~32'd3; m_valid = 0; m_out = nout; m_stale = nout; m_req = !nout;
    end else if (!m_started) m_req = 1;
    else if (a) begin
      m_req = 0; m_out = 1; m_stale = 0;
    end else if (m_out && bus.imem_rvalid) begin
      m_out = 0;
      if (m_stale) m_req = 1;
      else begin
        m_valid = 1; m_ipc = m_pc; m_instr = bus.imem_rdata;
      end
    end else if (m_valid && !stall) begin
      m_valid = 0; m_pc = m_pc + 32'd4; m_req = 1;
    end
    m_started = 1;
  endtask
  task automatic check_all;
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, m_req});
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("busy", {31'b0, busy}, {31'b0, m_out});
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    chk("if_pc", if_pc, m_ipc);
    chk("if_instr", if_instr, m_valid ? m_instr : NOP);
  endtask
  task automatic cyc;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask
  initial begin
    bus.imem_ready = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 0;
    bus.imem_ready = 1;
    cyc();
    // three back-to-back fetches, one instruction per three cycles
    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", bus.imem_addr, 32'(4 * i));
      bus.imem_ready = 1;
      cyc();
      bus.imem_ready = 0; bus.imem_rvalid = 1; bus.imem_rdata = 32'h1000 + 32'(i);
      cyc();
      bus.imem_rvalid = 0;
      chk("seq_pc", if_pc, 32'(4 * i));
      chk("seq_instr", if_instr, 32'h1000 + 32'(i));
      cyc();
    end
    // stall holds the buffered instruction for five cycles
    bus.imem_ready = 1;
    cyc();
    bus.imem_ready = 0; bus.imem_rvalid = 1; bus.imem_rdata = 32'hCAFE_0001;
    cyc();
    bus.imem_rvalid = 0; stall = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_pc", if_pc, 32'hC);
      chk("stall_req", {31'b0, bus.imem_req}, 32'h0);
    end
    stall = 0;
    cyc();
    chk("stall_next_addr", bus.imem_addr, 32'h10);
    // redirect in WAIT: late response dropped, fetch resumes at target
    bus.imem_ready = 1;
    cyc();
    bus.imem_ready = 0; redirect_valid = 1; redirect_pc = 32'h100;
    cyc();
    redirect_valid = 0;
    chk("drain_busy", {31'b0, busy}, 32'h1);
    cyc();
    bus.imem_rvalid = 1; bus.imem_rdata = 32'hDEAD_BEEF;
    cyc();
    bus.imem_rvalid = 0;
    chk("drain_valid", {31'b0, if_valid}, 32'h0);
    chk("drain_addr", bus.imem_addr, 32'h100);
    // redirect in HOLD under stall: unaligned target is masked
    bus.imem_ready = 1;
    cyc();
    bus.imem_ready = 0; bus.imem_rvalid = 1; bus.imem_rdata = 32'h1234_5678;
    cyc();
    bus.imem_rvalid = 0; stall = 1;
    cyc();
    redirect_valid = 1; redirect_pc = 32'h203;
    cyc();
    redirect_valid = 0; stall = 0;
    chk("hold_redir_valid", {31'b0, if_valid}, 32'h0);
    chk("hold_redir_addr", bus.imem_addr, 32'h200);
    // redirect coincident with rvalid in WAIT
    bus.imem_ready = 1;
    cyc();
    bus.imem_ready = 0; bus.imem_rvalid = 1; bus.imem_rdata = 32'hBAD0_0BAD;
    redirect_valid = 1; redirect_pc = 32'h340;
    cyc();
    bus.imem_rvalid = 0; redirect_valid = 0;
    chk("coinc_busy", {31'b0, busy}, 32'h0);
    chk("coinc_req", {31'b0, bus.imem_req}, 32'h1);
    chk("coinc_addr", bus.imem_addr, 32'h340);
    // asynchronous reset mid-WAIT
    bus.imem_ready = 1;
    cyc();
    bus.imem_ready = 0;
    #2 reset = 1;
    #1;
    model_reset();
    check_all();
    chk("areset_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    reset = 0;
    cyc();
    chk("areset_addr", bus.imem_addr, 32'h0);
    chk("areset_req", {31'b0, bus.imem_req}, 32'h1);
    // random traffic with a single-outstanding memory responder
    pend = 0; cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      bus.imem_rvalid = 0;
      bus.imem_rdata = $urandom;
      if (pend) begin
        if (cnt == 0) begin
          bus.imem_rvalid = 1; pend = 0;
        end else cnt--;
      end
      bus.imem_ready = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 2) == 0;
      redirect_valid = $urandom_range(0, 9) == 0;
      redirect_pc = $urandom;
      acc = bus.imem_req && bus.imem_ready;
      cyc();
      if (acc) begin
        pend = 1; cnt = $urandom_range(0, 2);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
